// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush scheduler: load-use bubbles, memory-wait freeze, branch squash,
// halt drain, memory watchdog and saturating stall counter.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_WORDS    = 32,
   parameter int unsigned MEM_TIMEOUT  = 64,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned CNT_BITS     = 32,
   localparam int unsigned ADDR_LEFT   = $clog2(REG_WORDS) - 1
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [ADDR_LEFT:0]  rs_s2,
   input  logic [ADDR_LEFT:0]  rt_s2,
   input  logic                use_rs_s2,
   input  logic                use_rt_s2,
   input  logic                sel_mem_s3,
   input  logic                rw_s3,
   input  logic [ADDR_LEFT:0]  waddr_s3,
   input  logic                branch_taken_s3,
   input  logic                sel_mem_s4,
   input  logic                mem_rw_s4,
   input  logic                halt_s4,
   input  logic                dmem_ready,
   output logic                pc_en,
   output logic                ifid_en,
   output logic                idex_en,
   output logic                exmem_en,
   output logic                memwb_en,
   output logic                ifid_flush,
   output logic                idex_flush,
   output logic                halted,
   output logic                mem_err,
   output logic [CNT_BITS-1:0] stall_cnt
);

   localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]          state, state_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic [DRAIN_W-1:0]  drain_cnt, drain_nxt;
   logic [CNT_BITS-1:0] stall_nxt;
   logic                err_nxt;
   logic                mem_busy;
   logic                load_use;

   assign mem_busy = (sel_mem_s4 | mem_rw_s4) & ~dmem_ready;
   assign load_use = sel_mem_s3 & rw_s3 & (waddr_s3 != '0) &
                     ((use_rs_s2 & (waddr_s3 == rs_s2)) | (use_rt_s2 & (waddr_s3 == rt_s2)));

   // State register and all registered bookkeeping
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state     <= ST_RUN;
         wait_cnt  <= '0;
         drain_cnt <= '0;
         stall_cnt <= '0;
         mem_err   <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         drain_cnt <= drain_nxt;
         stall_cnt <= stall_nxt;
         mem_err   <= err_nxt;
         halted    <= (state_nxt == ST_HALTED);
      end
   end

   // Next-state, enable/flush decode, watchdog and stall accounting
   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      state_nxt  = state;
      wait_nxt   = wait_cnt;
      drain_nxt  = drain_cnt;
      stall_nxt  = stall_cnt;
      err_nxt    = 1'b0;

      case (state)
         ST_RUN: begin
            if (!mem_busy) begin
               ifid_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
               pc_en    = 1'b1;
               if (branch_taken_s3) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (load_use) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
               end
               if (halt_s4) begin
                  state_nxt = ST_DRAIN;
                  drain_nxt = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (!mem_busy) begin
               ifid_en    = 1'b1;
               idex_en    = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1))
                  state_nxt = ST_HALTED;
               else
                  drain_nxt = drain_cnt + DRAIN_W'(1);
            end
         end
         default: begin
            state_nxt = ST_HALTED;
         end
      endcase

      // HALTED ignores inputs, so watchdog and stall counter only run while active
      if (state == ST_RUN || state == ST_DRAIN) begin
         if (mem_busy) begin
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
               err_nxt  = 1'b1;
               wait_nxt = '0;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end else begin
            wait_nxt = '0;
         end
         if (!pc_en && stall_cnt != '1)
            stall_nxt = stall_cnt + CNT_BITS'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded random/directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned REG_WORDS    = 32;
   localparam int unsigned MEM_TIMEOUT  = 4;
   localparam int unsigned DRAIN_CYCLES = 2;
   localparam int unsigned CNT_BITS     = 8;
   localparam int unsigned AW           = $clog2(REG_WORDS);

   typedef struct packed {
      logic          rst_n;
      logic [AW-1:0] rs, rt;
      logic          use_rs, use_rt, ld3, rw3;
      logic [AW-1:0] waddr;
      logic          br, ld4, st4, halt, ready;
   } stim_t;

   typedef struct packed {
      logic pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex, halted, err;
      logic [CNT_BITS-1:0] stalls;
   } obs_t;

   logic clk = 1'b0;
   logic rst_ = 1'b0;
   logic [AW-1:0] rs_s2 = '0, rt_s2 = '0, waddr_s3 = '0;
   logic use_rs_s2 = 0, use_rt_s2 = 0, sel_mem_s3 = 0, rw_s3 = 0, branch_taken_s3 = 0;
   logic sel_mem_s4 = 0, mem_rw_s4 = 0, halt_s4 = 0, dmem_ready = 1;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted, mem_err;
   logic [CNT_BITS-1:0] stall_cnt;

   pipe_hazard_ctrl #(.REG_WORDS(REG_WORDS), .MEM_TIMEOUT(MEM_TIMEOUT),
                      .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_BITS(CNT_BITS)) dut (
      .clk(clk), .rst_(rst_), .rs_s2(rs_s2), .rt_s2(rt_s2), .use_rs_s2(use_rs_s2),
      .use_rt_s2(use_rt_s2), .sel_mem_s3(sel_mem_s3), .rw_s3(rw_s3), .waddr_s3(waddr_s3),
      .branch_taken_s3(branch_taken_s3), .sel_mem_s4(sel_mem_s4), .mem_rw_s4(mem_rw_s4),
      .halt_s4(halt_s4), .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: phase is "run", "drain" or "halted" as a small integer
   int m_phase, m_wait, m_drained, m_stalls;
   bit m_err;

   function automatic void model_reset();
      m_phase = 0; m_wait = 0; m_drained = 0; m_stalls = 0; m_err = 0;
   endfunction

   task automatic step(input stim_t s);
      obs_t e;
      bit busy, hazard;
      @(posedge clk); #1;
      rst_ = s.rst_n; rs_s2 = s.rs; rt_s2 = s.rt; use_rs_s2 = s.use_rs; use_rt_s2 = s.use_rt;
      sel_mem_s3 = s.ld3; rw_s3 = s.rw3; waddr_s3 = s.waddr; branch_taken_s3 = s.br;
      sel_mem_s4 = s.ld4; mem_rw_s4 = s.st4; halt_s4 = s.halt; dmem_ready = s.ready;
      if (!s.rst_n) model_reset();
      busy   = (s.ld4 || s.st4) && !s.ready;
      hazard = s.ld3 && s.rw3 && s.waddr != 0 &&
               ((s.use_rs && s.waddr == s.rs) || (s.use_rt && s.waddr == s.rt));
      e = '0;
      e.halted = (m_phase == 2);
      e.err    = m_err;
      e.stalls = CNT_BITS'(m_stalls);
      if (m_phase != 2 && !busy) begin
         {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b11111;
         if (m_phase == 1) begin
            e.pc = 0; e.fl_ifid = 1; e.fl_idex = 1;
         end else if (s.br) begin
            e.fl_ifid = 1; e.fl_idex = 1;
         end else if (hazard) begin
            e.pc = 0; e.ifid = 0; e.fl_idex = 1;
         end
      end
      exp_q.push_back(e);
      if (s.rst_n && m_phase != 2) begin
         m_err = 0;
         if (!busy) m_wait = 0;
         else if (m_wait + 1 == MEM_TIMEOUT) begin m_err = 1; m_wait = 0; end
         else m_wait++;
         if (!e.pc && m_stalls < (1 << CNT_BITS) - 1) m_stalls++;
         if (!busy) begin
            if (m_phase == 0 && s.halt) begin m_phase = 1; m_drained = 0; end
            else if (m_phase == 1) begin
               m_drained++;
               if (m_drained == DRAIN_CYCLES) m_phase = 2;
            end
         end
      end
   endtask

   // Monitor: compares every presented cycle against the next scoreboard entry
   always @(negedge clk) begin
      obs_t a, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, mem_err, stall_cnt};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, a, e);
         end
      end
   end

   function automatic stim_t idle();
      stim_t s = '0;
      s.rst_n = 1; s.ready = 1;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s = idle();
      s.rs = AW'($urandom_range(0, 3)); s.rt = AW'($urandom_range(0, 3));
      s.waddr = AW'($urandom_range(0, 3));
      s.use_rs = 1'($urandom); s.use_rt = 1'($urandom);
      s.ld3 = 1'($urandom); s.rw3 = ($urandom_range(0, 3) != 0);
      s.br = ($urandom_range(0, 5) == 0);
      s.ld4 = ($urandom_range(0, 3) == 0); s.st4 = ($urandom_range(0, 3) == 0);
      s.ready = ($urandom_range(0, 2) != 0);
      s.halt = ($urandom_range(0, 80) == 0);
      return s;
   endfunction

   initial begin
      stim_t s;
      model_reset();
      // Reset held for a few cycles
      s = idle(); s.rst_n = 0;
      repeat (3) step(s);
      // Load-use on rt, then variants without hazard and with branch override
      s = idle(); s.ld3 = 1; s.rw3 = 1; s.waddr = 5; s.rt = 5; s.use_rt = 1;
      step(s); step(idle());
      s.waddr = 0; s.rt = 0; step(s);
      s.waddr = 5; s.rt = 5; s.use_rt = 0; step(s);
      s.use_rt = 1; s.br = 1; step(s);
      s.br = 0; s.use_rt = 0; s.use_rs = 1; s.rs = 5; step(s);
      // Store waiting three cycles, then a ten-cycle load wait with watchdog expiries
      s = idle(); s.st4 = 1; s.ready = 0;
      repeat (3) step(s);
      s.ready = 1; step(s);
      s = idle(); s.ld4 = 1; s.ready = 0;
      repeat (10) step(s);
      s.ready = 1; step(s);
      // Halt, drain and stay halted with noisy inputs
      s = idle(); s.halt = 1; step(s);
      repeat (6) step(rand_stim());
      // Reset during a drain
      s = idle(); s.rst_n = 0; step(s); step(idle());
      s = idle(); s.halt = 1; step(s); step(idle());
      s = idle(); s.rst_n = 0; step(s);
      repeat (2) step(idle());
      // Long freeze to saturate the stall counter
      s = idle(); s.st4 = 1; s.ready = 0;
      repeat (270) step(s);
      step(idle());
      s = idle(); s.rst_n = 0; step(s);
      // Random traffic with occasional resets
      for (int i = 0; i < 2500; i++) begin
         s = rand_stim();
         if ($urandom_range(0, 199) == 0 || (m_phase == 2 && $urandom_range(0, 7) == 0))
            s.rst_n = 0;
         step(s);
      end
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
